// File: rtl/load_store_unit.sv
// Load/store unit: one handshaked word-bus transaction per load/store, returns lane-extracted load data.
// Latency: 3 cycles best case (IDLE->WAIT->DONE), +1 per ack wait cycle; illegal access 2 cycles, no bus cycle.
// Backpressure: stall holds the core while the access is pending; optional LSU_BUS_TIMEOUT_EN aborts after TIMEOUT_CYCLES.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  func3,
  input  logic [31:0] ALU_result,
  input  logic [31:0] MEM_w_data,
  output logic        stall,
  output logic [31:0] MEM_r_data,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Transaction context kept for the load extraction at ack time
  logic        lat_load;
  logic [2:0]  lat_func3;
  logic [1:0]  lat_off;

  // Decode / FSM strobes
  logic        access_req;
  logic        func3_legal;
  logic        aligned;
  logic        access_ok;
  logic        launch;
  logic        reject;
  logic        complete;
  logic        abort;
  logic        timeout_hit;

  // Store lane placement for the current instruction
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  // Pick the addressed lane and extend it according to the load type
  function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = w;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Classify the requested access: legal width code and natural alignment
  always_comb begin
    access_req  = MemRead | MemWrite;
    func3_legal = 1'b0;
    aligned     = 1'b0;
    case (func3)
      3'b000, 3'b100: begin
        func3_legal = 1'b1;
        aligned     = 1'b1;
      end
      3'b001, 3'b101: begin
        func3_legal = 1'b1;
        aligned     = ~ALU_result[0];
      end
      3'b010: begin
        func3_legal = 1'b1;
        aligned     = (ALU_result[1:0] == 2'b00);
      end
      default: begin
        func3_legal = 1'b0;
        aligned     = 1'b0;
      end
    endcase
    // Loads may only ever be sized; stores use only the low two func3 bits but
    // share the same legality table so U-variants of stores are also accepted
    access_ok = (MemRead ^ MemWrite) & func3_legal & aligned;
  end

  // Replicate store data across lanes and derive byte enables from size and offset
  always_comb begin
    st_be    = 4'b0000;
    st_wdata = 32'd0;
    case (func3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << ALU_result[1:0];
        st_wdata = {4{MEM_w_data[7:0]}};
      end
      2'b01: begin
        st_be    = ALU_result[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{MEM_w_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = MEM_w_data;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state, stall and transaction strobes
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    launch    = 1'b0;
    reject    = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (access_req) begin
          stall = 1'b1;
          if (access_ok) begin
            launch    = 1'b1;
            state_nxt = WAIT;
          end else begin
            reject    = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        // A same-cycle ack takes priority over the timeout abort
        if (bus_ack) begin
          complete  = 1'b1;
          state_nxt = DONE;
        end else if (timeout_hit) begin
          abort     = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        // Core inputs are ignored here so the same instruction is not relaunched
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Bus request/attributes, transaction context, load data and misalign pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= 32'd0;
      bus_be       <= 4'b0000;
      bus_wdata    <= 32'd0;
      MEM_r_data   <= 32'd0;
      misalign_err <= 1'b0;
      lat_load     <= 1'b0;
      lat_func3    <= 3'd0;
      lat_off      <= 2'd0;
    end else begin
      misalign_err <= reject;
      if (launch) begin
        bus_req   <= 1'b1;
        bus_we    <= MemWrite;
        bus_addr  <= {ALU_result[31:2], 2'b00};
        bus_be    <= MemWrite ? st_be : 4'b0000;
        bus_wdata <= MemWrite ? st_wdata : 32'd0;
        lat_load  <= MemRead;
        lat_func3 <= func3;
        lat_off   <= ALU_result[1:0];
      end
      if (complete) begin
        bus_req    <= 1'b0;
        MEM_r_data <= lat_load ? load_extract(lat_func3, lat_off, bus_rdata) : 32'd0;
      end
      if (reject || abort) begin
        bus_req    <= 1'b0;
        MEM_r_data <= 32'd0;
      end
    end
  end

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;

  assign timeout_hit = (state == WAIT) && (wait_cnt == CNT_LAST);

  // Count WAIT cycles from zero on each launch; raise the bus error pulse on abort
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      bus_err <= abort;
      if (launch) begin
        wait_cnt <= '0;
      end else if ((state == WAIT) && !timeout_hit) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end
`else
  // Without the watchdog the bus may stall indefinitely and never errors
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;

  wire unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  func3;
  logic [31:0] ALU_result;
  logic [31:0] MEM_w_data;
  logic        stall;
  logic [31:0] MEM_r_data;
  logic        misalign_err;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_cmp = 0;
  int n_err = 0;

  // Bus attributes snapshotted in the first WAIT cycle of the last access
  logic        saw_req;
  logic        unstable;
  logic        snap_we;
  logic [31:0] snap_addr;
  logic [3:0]  snap_be;
  logic [31:0] snap_wdata;
  int          stalls;

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .func3        (func3),
    .ALU_result   (ALU_result),
    .MEM_w_data   (MEM_w_data),
    .stall        (stall),
    .MEM_r_data   (MEM_r_data),
    .misalign_err (misalign_err),
    .bus_err      (bus_err),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_be       (bus_be),
    .bus_wdata    (bus_wdata),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one instruction from IDLE (called 1ns after a rising edge).
  // ack_after = index of the WAIT cycle in which ack is driven, -1 = never.
  // Returns 2ns after the edge that leaves the stall (normally in DONE).
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdat, input int ack_after);
    int wc;
    MemRead    = rd;
    MemWrite   = wr;
    func3      = f3;
    ALU_result = a;
    MEM_w_data = wd;
    bus_rdata  = rdat;
    bus_ack    = 1'b0;
    stalls     = 0;
    wc         = 0;
    saw_req    = 1'b0;
    unstable   = 1'b0;
    #1;
    while (stall && stalls < 64) begin
      stalls++;
      @(posedge clk);
      #1;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      if (bus_req) begin
        if (!saw_req) begin
          snap_we    = bus_we;
          snap_addr  = bus_addr;
          snap_be    = bus_be;
          snap_wdata = bus_wdata;
        end else if (bus_we !== snap_we || bus_addr !== snap_addr ||
                     bus_be !== snap_be || bus_wdata !== snap_wdata) begin
          unstable = 1'b1;
        end
        saw_req = 1'b1;
        bus_ack = (wc == ack_after);
        wc++;
      end else begin
        bus_ack = 1'b0;
      end
      #1;
    end
    bus_ack = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    func3      = 3'b000;
    ALU_result = 32'd0;
    MEM_w_data = 32'd0;
    bus_ack    = 1'b0;
    bus_rdata  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_we", bus_we, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_be", bus_be, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_rdata", MEM_r_data, 0);
    check("rst_misalign", misalign_err, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_stall", stall, 0);
    rst = 1'b1;
    next_cycle();
    check("idle_stall", stall, 0);

    // SW 0x104
    access(1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 0);
    check("sw_stalls", 32'(stalls), 2);
    check("sw_addr", snap_addr, 32'h104);
    check("sw_be", 32'(snap_be), 32'hF);
    check("sw_wdata", snap_wdata, 32'hDEADBEEF);
    check("sw_we", 32'(snap_we), 1);
    check("sw_done_req", bus_req, 0);
    check("sw_done_stall", stall, 0);
    check("sw_done_rdata", MEM_r_data, 0);
    check("sw_done_mis", misalign_err, 0);
    next_cycle();

    // SB 0x103 with two wait cycles: lanes and attribute stability
    access(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 2);
    check("sb_stalls", 32'(stalls), 4);
    check("sb_addr", snap_addr, 32'h100);
    check("sb_be", 32'(snap_be), 32'h8);
    check("sb_wdata", snap_wdata, 32'hA5A5A5A5);
    check("sb_stable", 32'(unstable), 0);
    next_cycle();

    // SH 0x102
    access(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 0);
    check("sh_be", 32'(snap_be), 32'hC);
    check("sh_wdata", snap_wdata, 32'hABCDABCD);
    next_cycle();

    // LB 0x102 sign-extends lane 2
    access(1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 32'h0080FF00, 1);
    check("lb_stalls", 32'(stalls), 3);
    check("lb_addr", snap_addr, 32'h100);
    check("lb_be", 32'(snap_be), 0);
    check("lb_we", 32'(snap_we), 0);
    check("lb_data", MEM_r_data, 32'hFFFFFF80);
    next_cycle();
    check("lb_hold_idle", MEM_r_data, 32'hFFFFFF80);

    access(1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 32'h0080FF00, 0);
    check("lbu_data", MEM_r_data, 32'h00000080);
    next_cycle();
    access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h0080FF00, 0);
    check("lhu_data", MEM_r_data, 32'h00000080);
    next_cycle();
    access(1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 32'h00008001, 0);
    check("lh_data", MEM_r_data, 32'hFFFF8001);
    next_cycle();
    access(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'h12345678, 0);
    check("lw_data", MEM_r_data, 32'h12345678);
    next_cycle();

    // Misaligned LW: no bus cycle, one stall cycle, one-cycle error pulse
    access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'hFFFFFFFF, 0);
    check("mis_stalls", 32'(stalls), 1);
    check("mis_req_seen", 32'(saw_req), 0);
    check("mis_pulse", misalign_err, 1);
    check("mis_rdata", MEM_r_data, 0);
    check("mis_bus_err", bus_err, 0);
    next_cycle();
    check("mis_pulse_end", misalign_err, 0);

    // Both read and write set
    access(1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 32'h0, 0);
    check("rw_req_seen", 32'(saw_req), 0);
    check("rw_pulse", misalign_err, 1);
    next_cycle();

    // Reserved func3
    access(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
    check("f3_req_seen", 32'(saw_req), 0);
    check("f3_pulse", misalign_err, 1);
    next_cycle();

    // Misaligned halfword store
    access(1'b0, 1'b1, 3'b001, 32'h103, 32'h0, 32'h0, 0);
    check("shmis_pulse", misalign_err, 1);
    next_cycle();

`ifdef LSU_BUS_TIMEOUT_EN
    // Ack withheld: abort after 16 WAIT cycles
    access(1'b1, 1'b0, 3'b010, 32'h108, 32'h0, 32'h55555555, -1);
    check("to_stalls", 32'(stalls), 17);
    check("to_bus_err", bus_err, 1);
    check("to_req", bus_req, 0);
    check("to_rdata", MEM_r_data, 0);
    next_cycle();
    check("to_pulse_end", bus_err, 0);

    // Ack on the 16th WAIT cycle wins over the abort
    access(1'b1, 1'b0, 3'b010, 32'h108, 32'h0, 32'h55555555, 15);
    check("to_ack_stalls", 32'(stalls), 17);
    check("to_ack_err", bus_err, 0);
    check("to_ack_rdata", MEM_r_data, 32'h55555555);
    next_cycle();
`else
    // No watchdog: a long wait completes normally
    access(1'b1, 1'b0, 3'b010, 32'h108, 32'h0, 32'h55555555, 30);
    check("long_stalls", 32'(stalls), 32);
    check("long_bus_err", bus_err, 0);
    check("long_rdata", MEM_r_data, 32'h55555555);
    next_cycle();
`endif

    // Reset during WAIT
    MemRead    = 1'b1;
    func3      = 3'b010;
    ALU_result = 32'h200;
    next_cycle();
    MemRead = 1'b0;
    check("rw_wait_req", bus_req, 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_req", bus_req, 0);
    check("arst_stall", stall, 0);
    bus_ack = 1'b1;
    next_cycle();
    rst = 1'b1;
    next_cycle();
    check("late_ack_req", bus_req, 0);
    check("late_ack_stall", stall, 0);
    check("late_ack_rdata", MEM_r_data, 0);
    bus_ack = 1'b0;
    next_cycle();
    access(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'hCAFEF00D, 0);
    check("post_rst_stalls", 32'(stalls), 2);
    check("post_rst_addr", snap_addr, 32'h200);
    check("post_rst_rdata", MEM_r_data, 32'hCAFEF00D);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
